// File: rtl/mult_result_checker.sv
// In-line checker for the shift-add multiplier handshake and product.
// Flags bad products, starts while not ready, and missing done within a budget.
module mult_result_checker #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               rdy,
  input  logic               done,
  input  logic [2*WIDTH-1:0] product,
  output logic               bad_product,
  output logic               not_ready,
  output logic               timeout,
  output logic               busy,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_WDL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [TW-1:0]    r_cnt;
  logic             r_bad;
  logic             r_nr;
  logic             r_tmo;
  logic [CNT_W-1:0] r_txn;
  logic [CNT_W-1:0] r_err;

  logic             w_accept;
  logic             w_fin;
  logic             w_bad;
  logic             w_nr;
  logic             w_tmo;
  logic [1:0]       w_nerr;
  logic [PW-1:0]    w_exp;
  logic [CNT_W:0]   w_err_sum;
  logic [CNT_W:0]   w_txn_sum;

  assign w_exp = PW'(r_a) * PW'(r_b);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_BUSY;
      S_BUSY: begin
        if (done)       w_next = S_WDL;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_WDL: begin
        if (w_accept)   w_next = S_BUSY;
        else if (!done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Holding done high after completion still lets a new start be accepted.
  always_comb begin
    w_accept = start && rdy && (r_state != S_BUSY);
    w_nr     = start && ((r_state == S_BUSY) || !rdy);
    w_fin    = (r_state == S_BUSY) && done;
    w_bad    = w_fin && (product != w_exp);
    w_tmo    = (r_state == S_BUSY) && !done
               && (r_cnt == TW'(TIMEOUT_CYCLES - 1));
    w_nerr   = 2'(w_bad) + 2'(w_nr) + 2'(w_tmo);
    w_err_sum = {1'b0, r_err} + (CNT_W+1)'(w_nerr);
    w_txn_sum = {1'b0, r_txn} + (CNT_W+1)'(w_fin);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_bad <= 1'b0;
      r_nr  <= 1'b0;
      r_tmo <= 1'b0;
      r_txn <= '0;
      r_err <= '0;
    end else begin
      r_bad <= w_bad;
      r_nr  <= w_nr;
      r_tmo <= w_tmo;
      if (w_accept) begin
        r_a   <= multiplicand;
        r_b   <= multiplier;
        r_cnt <= '0;
      end else if (r_state == S_BUSY && !done && !w_tmo) begin
        r_cnt <= r_cnt + TW'(1);
      end
      // Counters clamp at all-ones instead of wrapping.
      r_txn <= w_txn_sum[CNT_W] ? '1 : w_txn_sum[CNT_W-1:0];
      r_err <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    end
  end

  assign bad_product = r_bad;
  assign not_ready   = r_nr;
  assign timeout     = r_tmo;
  assign busy        = (r_state == S_BUSY);
  assign txn_count   = r_txn;
  assign err_count   = r_err;

endmodule

// File: tb/tb_mult_result_checker.sv
// Directed bench for mult_result_checker.
// A second instance with 2-bit counters exercises saturation.
module tb_mult_result_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        rdy;
  logic        done;
  logic [15:0] product;

  logic        bad;
  logic        nr;
  logic        tmo;
  logic        bsy;
  logic [15:0] txn;
  logic [15:0] err;

  logic        s_bad;
  logic        s_nr;
  logic        s_tmo;
  logic        s_bsy;
  logic [1:0]  s_txn;
  logic [1:0]  s_err;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mult_result_checker u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .rdy          (rdy),
    .done         (done),
    .product      (product),
    .bad_product  (bad),
    .not_ready    (nr),
    .timeout      (tmo),
    .busy         (bsy),
    .txn_count    (txn),
    .err_count    (err)
  );

  mult_result_checker #(.CNT_W(2)) u_sat (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .rdy          (rdy),
    .done         (done),
    .product      (product),
    .bad_product  (s_bad),
    .not_ready    (s_nr),
    .timeout      (s_tmo),
    .busy         (s_bsy),
    .txn_count    (s_txn),
    .err_count    (s_err)
  );

  task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb,
                         input logic [15:0] tp, input int hold,
                         output int nbad);
    nbad = 0;
    @(negedge clk);
    start = 1'b1; rdy = 1'b1; a = ta; b = tb;
    @(negedge clk);
    start = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    done = 1'b1; product = tp; rdy = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      nbad += int'(bad);
    end
    done = 1'b0;
    @(negedge clk);
    nbad += int'(bad);
    @(negedge clk);
    nbad += int'(bad);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
    rdy = 1'b1; done = 1'b0; product = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tests++;
    if ({bad, nr, tmo, bsy, txn, err} !== 20'd0) begin
      failed++;
      $display("FAIL reset: got %b/%b/%b/%b txn=%0d err=%0d want 0",
               bad, nr, tmo, bsy, txn, err);
    end
  endtask

  task automatic test_basic();
    int n;
    run_txn(8'd13, 8'd11, 16'd143, 1, n);
    tests++;
    if (n !== 0 || txn !== 16'd1 || err !== 16'd0 || bsy !== 1'b0) begin
      failed++;
      $display("FAIL basic: bad=%0d txn=%0d err=%0d busy=%b want 0/1/0/0",
               n, txn, err, bsy);
    end
  endtask

  task automatic test_max();
    int n;
    run_txn(8'd255, 8'd255, 16'hFE01, 1, n);
    tests++;
    if (n !== 0 || txn !== 16'd2 || err !== 16'd0) begin
      failed++;
      $display("FAIL max_ok: bad=%0d txn=%0d err=%0d want 0/2/0", n, txn, err);
    end
    run_txn(8'd255, 8'd255, 16'hFE00, 1, n);
    tests++;
    if (n !== 1 || txn !== 16'd3 || err !== 16'd1) begin
      failed++;
      $display("FAIL max_bad: bad=%0d txn=%0d err=%0d want 1/3/1", n, txn, err);
    end
  endtask

  task automatic test_not_ready();
    @(negedge clk);
    start = 1'b1; rdy = 1'b0; a = 8'd1; b = 8'd1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (nr !== 1'b1 || bsy !== 1'b0) begin
      failed++;
      $display("FAIL nr_idle: nr=%b busy=%b want 1/0", nr, bsy);
    end
    @(negedge clk);
    tests++;
    if (nr !== 1'b0) begin
      failed++;
      $display("FAIL nr_width: nr=%b want 0", nr);
    end
    start = 1'b1; rdy = 1'b1; a = 8'd7; b = 8'd9;
    @(negedge clk);
    start = 1'b0; rdy = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd200;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (nr !== 1'b1 || bsy !== 1'b1) begin
      failed++;
      $display("FAIL nr_busy: nr=%b busy=%b want 1/1", nr, bsy);
    end
    done = 1'b1; product = 16'd63; rdy = 1'b1;
    @(negedge clk);
    done = 1'b0;
    tests++;
    if (bad !== 1'b0 || nr !== 1'b0 || err !== 16'd3 || txn !== 16'd4) begin
      failed++;
      $display("FAIL nr_keep: bad=%b nr=%b err=%0d txn=%0d want 0/0/3/4",
               bad, nr, err, txn);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    start = 1'b1; rdy = 1'b1; a = 8'd3; b = 8'd5;
    @(negedge clk);
    start = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      early += int'(tmo);
    end
    @(negedge clk);
    tests++;
    if (early !== 0 || tmo !== 1'b1 || bsy !== 1'b0) begin
      failed++;
      $display("FAIL timeout: early=%0d tmo=%b busy=%b want 0/1/0",
               early, tmo, bsy);
    end
    @(negedge clk);
    tests++;
    if (tmo !== 1'b0 || txn !== 16'd4 || err !== 16'd4) begin
      failed++;
      $display("FAIL tmo_after: tmo=%b txn=%0d err=%0d want 0/4/4",
               tmo, txn, err);
    end
    tests++;
    if (s_err !== 2'b11 || s_txn !== 2'b11) begin
      failed++;
      $display("FAIL saturate: err=%b txn=%b want 11/11", s_err, s_txn);
    end
  endtask

  task automatic test_mid_reset();
    rdy = 1'b1; start = 1'b1; a = 8'd9; b = 8'd9;
    @(negedge clk);
    start = 1'b0; rdy = 1'b0;
    @(negedge clk);
    start = 1'b1; reset_n = 1'b0;
    @(negedge clk);
    start = 1'b0; reset_n = 1'b1; rdy = 1'b1;
    tests++;
    if ({bad, nr, tmo, bsy, txn, err} !== 20'd0 || s_err !== 2'b00) begin
      failed++;
      $display("FAIL mid_reset: %b/%b/%b/%b txn=%0d err=%0d want 0",
               bad, nr, tmo, bsy, txn, err);
    end
  endtask

  task automatic test_hold3();
    int n;
    run_txn(8'd10, 8'd10, 16'd101, 3, n);
    tests++;
    if (n !== 1 || txn !== 16'd1 || err !== 16'd1) begin
      failed++;
      $display("FAIL hold3: bad=%0d txn=%0d err=%0d want 1/1/1", n, txn, err);
    end
  endtask

  task automatic test_coincide();
    start = 1'b1; rdy = 1'b1; a = 8'd2; b = 8'd3;
    @(negedge clk);
    start = 1'b0; rdy = 1'b0;
    @(negedge clk);
    done = 1'b1; product = 16'd7; start = 1'b1;
    @(negedge clk);
    done = 1'b0; start = 1'b0; rdy = 1'b1;
    tests++;
    if (bad !== 1'b1 || nr !== 1'b1 || err !== 16'd3 || txn !== 16'd2) begin
      failed++;
      $display("FAIL coincide: bad=%b nr=%b err=%0d txn=%0d want 1/1/3/2",
               bad, nr, err, txn);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; rdy = 1'b1; a = 8'd4; b = 8'd4;
    @(negedge clk);
    start = 1'b0; rdy = 1'b0;
    @(negedge clk);
    done = 1'b1; product = 16'd16; rdy = 1'b1;
    @(negedge clk);
    start = 1'b1; a = 8'd5; b = 8'd6;
    @(negedge clk);
    start = 1'b0; done = 1'b0; rdy = 1'b0;
    tests++;
    if (bsy !== 1'b1 || bad !== 1'b0 || nr !== 1'b0) begin
      failed++;
      $display("FAIL b2b_accept: busy=%b bad=%b nr=%b want 1/0/0",
               bsy, bad, nr);
    end
    @(negedge clk);
    done = 1'b1; product = 16'd30; rdy = 1'b1;
    @(negedge clk);
    done = 1'b0;
    tests++;
    if (bad !== 1'b0 || txn !== 16'd4 || err !== 16'd3) begin
      failed++;
      $display("FAIL b2b_done: bad=%b txn=%0d err=%0d want 0/4/3",
               bad, txn, err);
    end
    @(negedge clk);
    tests++;
    if (bsy !== 1'b0) begin
      failed++;
      $display("FAIL b2b_idle: busy=%b want 0", bsy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_not_ready();
    test_timeout();
    test_mid_reset();
    test_hold3();
    test_coincide();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mult_result_checker.md
Name: mult_result_checker

Overview:
- Synthesizable in-line checker placed directly downstream of the shift-add multiplier; monitors the multiplier's start/ready/done handshake and product bus.
- Latches the operands when a multiply is accepted, computes the reference product, and compares it when done asserts.
- Raises single-cycle BAD_PRODUCT, NOT_READY and TIMEOUT flags, and keeps transaction/error counters readable by the bench or a debug register.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH.
- TIMEOUT_CYCLES, 64, maximum cycles from accepted start to done before TIMEOUT fires.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  multiplier start request, sampled every cycle.
- multiplicand  in  WIDTH  operand A, valid with start.
- multiplier  in  WIDTH  operand B, valid with start.
- rdy  in  1  multiplier ready (idle) indication.
- done  in  1  multiplier completion indication, single or multi cycle.
- product  in  2*WIDTH  multiplier result, valid while done=1.
- bad_product  out  1  one-cycle pulse: product mismatch.
- not_ready  out  1  one-cycle pulse: start asserted while rdy=0.
- timeout  out  1  one-cycle pulse: done not seen within TIMEOUT_CYCLES.
- busy  out  1  checker is tracking an in-flight multiply.
- txn_count  out  CNT_W  completed (done-observed) transactions.
- err_count  out  CNT_W  total bad_product + not_ready + timeout pulses.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE, all pulses 0, busy 0, counters 0, latched operands 0, cycle counter 0. Reset mid-operation abandons the transaction with no flag.
- States: IDLE, BUSY, WAIT_DONE_LOW.
- IDLE: start=1 && rdy=1 -> latch A,B, expected = A*B (unsigned, 2*WIDTH, no truncation), cycle counter = 0, go BUSY, busy=1 next cycle.
- IDLE: start=1 && rdy=0 -> not_ready pulse next cycle; state unchanged.
- BUSY: cycle counter increments each cycle. done=1 -> compare product to expected; mismatch -> bad_product pulse next cycle; txn_count += 1; go WAIT_DONE_LOW.
- BUSY: start=1 (any rdy) -> not_ready pulse; operands are not re-latched. If done and start coincide, both checks apply and both pulses fire in the same cycle.
- BUSY: counter reaches TIMEOUT_CYCLES without done -> timeout pulse, go IDLE, busy=0; txn_count unchanged.
- WAIT_DONE_LOW: done held high is one transaction, not re-checked. done=0 -> IDLE. A start with rdy=1 while done=1 in this state is accepted as a new transaction (go BUSY), matching a multiplier that returns to ready while done is still held.
- Pulse latency: every flag is registered and is high exactly one cycle, in the cycle after the triggering sample.
- err_count adds the number of flags asserted that cycle (0-3). Counters saturate at all-ones and do not wrap.

Test Plan:
- Reset, then A=8'd13, B=8'd11 accepted with rdy=1; product=16'd143 at done -> no flags; txn_count=1; err_count=0; busy returns 0 after done drops.
- A=8'd255, B=8'd255; product=16'hFE01 is correct -> no flag. Repeat with product=16'hFE00 -> bad_product high exactly one cycle; err_count=1.
- start pulsed while rdy=0 in IDLE, then again mid-BUSY -> two not_ready pulses; latched operands unchanged; the original correct product still passes.
- start accepted, done withheld for TIMEOUT_CYCLES -> timeout pulse at cycle 64+1; state IDLE; txn_count unchanged. Then drive reset_n=0 mid-BUSY on a new multiply -> all outputs and counters are 0 the next cycle.
- done held 3 cycles with a wrong product -> exactly one bad_product pulse; txn_count increments once.
- Force err_count to all-ones via CNT_W=2 and 4 errors -> err_count stays 2'b11.
